i2c_read_burst_sequencer: RTL and testbench

//  Upstream controller for the single-byte I2C read master. Takes one burst request
//  (device addr, start reg addr, byte count) and issues back-to-back single-byte reads,

---
 rtl/i2c_read_burst_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_read_burst_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_read_burst_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// i2c_read_burst_sequencer
//
// Purpose:
//   Sits upstream of a single-byte I2C read master. Accepts one burst request
//   (device address, start register address, byte count) and issues
//   back-to-back single-byte reads. The register address increments after
//   each read. Each returned byte is tagged with its register address, stored
//   in a small FIFO, and delivered on a valid/ready stream.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_req_valid/o_req_ready burst request handshake (ready only when idle)
//   i_dev_addr              7-bit slave address for the burst
//   i_start_addr            first register address
//   i_byte_count            bytes to read (0 means 256)
//   o_recv_en               one-cycle start pulse to the read master
//   o_device_addr           address to the read master, held between reads
//   o_data_addr             address to the read master, held between reads
//   i_read_data/i_done_flag byte and completion strobe from the read master
//   o_rd_valid/i_rd_ready   read-data stream handshake
//   o_rd_data/o_rd_addr     FIFO head: byte and its register address
//   o_busy                  sequencer not idle
//   o_burst_done            one-cycle pulse at the end of a burst (normal or abort)
//   o_timeout_err           sticky timeout flag, cleared by the next accepted request
// -----------------------------------------------------------------------------
module i2c_read_burst_sequencer #(
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd50000,
  parameter logic [7:0]  GAP_CYCLES     = 8'd250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [6:0] i_dev_addr,
  input  logic [7:0] i_start_addr,
  input  logic [7:0] i_byte_count,
  output logic       o_recv_en,
  output logic [6:0] o_device_addr,
  output logic [7:0] o_data_addr,
  input  logic [7:0] i_read_data,
  input  logic       i_done_flag,
  output logic       o_rd_valid,
  input  logic       i_rd_ready,
  output logic [7:0] o_rd_data,
  output logic [7:0] o_rd_addr,
  output logic       o_busy,
  output logic       o_burst_done,
  output logic       o_timeout_err
);

  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STORE,
    S_GAP,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       dev_addr_q, dev_addr_d;
  logic [7:0]       data_addr_q, data_addr_d;
  logic [8:0]       remaining_q, remaining_d;
  logic [19:0]      to_cnt_q, to_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [15:0]      cap_q, cap_d;

  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [15:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             push;
  logic             pop;
  logic             recv_en;
  logic             burst_done;

  // Sequencer FSM: next state and datapath updates
  always_comb begin
    state_d       = state_q;
    dev_addr_d    = dev_addr_q;
    data_addr_d   = data_addr_q;
    remaining_d   = remaining_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    timeout_err_d = timeout_err_q;
    cap_d         = cap_q;
    push          = 1'b0;
    recv_en       = 1'b0;
    burst_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          dev_addr_d    = i_dev_addr;
          data_addr_d   = i_start_addr;
          remaining_d   = (i_byte_count == 8'd0) ? 9'd256 : {1'b0, i_byte_count};
          timeout_err_d = 1'b0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Only start a read when its byte is guaranteed a FIFO slot, so the
        // push in STORE can never overflow.
        if (count_q < DEPTH_C) begin
          recv_en  = 1'b1;
          to_cnt_d = 20'd0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_done_flag) begin
          cap_d   = {i_read_data, data_addr_q};
          state_d = S_STORE;
        end else if (to_cnt_q == TIMEOUT_CYCLES - 20'd1) begin
          timeout_err_d = 1'b1;
          state_d       = S_FINISH;
        end else begin
          to_cnt_d = to_cnt_q + 20'd1;
        end
      end
      S_STORE: begin
        push        = 1'b1;
        remaining_d = remaining_q - 9'd1;
        data_addr_d = data_addr_q + 8'd1;
        if (remaining_q == 9'd1) begin
          state_d = S_FINISH;
        end else if (GAP_CYCLES == 8'd0) begin
          state_d = S_ISSUE;
        end else begin
          gap_cnt_d = 8'd0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_CYCLES - 8'd1) begin
          state_d = S_ISSUE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      S_FINISH: begin
        burst_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read-data FIFO: simultaneous push and pop leave the occupancy unchanged
  always_comb begin
    pop      = (count_q != '0) && i_rd_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = cap_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      dev_addr_q    <= '0;
      data_addr_q   <= '0;
      remaining_q   <= '0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      cap_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      dev_addr_q    <= dev_addr_d;
      data_addr_q   <= data_addr_d;
      remaining_q   <= remaining_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      timeout_err_q <= timeout_err_d;
      cap_q         <= cap_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_q         <= mem_d;
    end
  end

  // A push into a full FIFO would mean the ISSUE space check was bypassed
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && (count_q == DEPTH_C)));
    end
  end

  assign o_req_ready   = (state_q == S_IDLE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_recv_en     = recv_en;
  assign o_burst_done  = burst_done;
  assign o_device_addr = dev_addr_q;
  assign o_data_addr   = data_addr_q;
  assign o_timeout_err = timeout_err_q;
  assign o_rd_valid    = (count_q != '0);
  assign o_rd_data     = mem_q[rd_ptr_q][15:8];
  assign o_rd_addr     = mem_q[rd_ptr_q][7:0];

endmodule

// File: tb/tb_i2c_read_burst_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_i2c_read_burst_sequencer
//
// Directed bench for the burst read sequencer. A behavioural read-master model
// answers each o_recv_en with a done strobe after a programmable delay, using
// data seed+n for the n-th read of a burst. A consumer monitor logs every byte
// accepted on the output stream; a driver applies a fixed or throttled ready.
// Short timeout/gap parameters keep the run small.
// -----------------------------------------------------------------------------
module tb_i2c_read_burst_sequencer;

  localparam int          DEPTH = 4;
  localparam logic [19:0] TMO   = 20'd300;
  localparam logic [7:0]  GAP   = 8'd4;

  logic       clk;
  logic       rst_n;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [6:0] i_dev_addr;
  logic [7:0] i_start_addr;
  logic [7:0] i_byte_count;
  logic       o_recv_en;
  logic [6:0] o_device_addr;
  logic [7:0] o_data_addr;
  logic [7:0] i_read_data;
  logic       i_done_flag;
  logic       o_rd_valid;
  logic       i_rd_ready;
  logic [7:0] o_rd_data;
  logic [7:0] o_rd_addr;
  logic       o_busy;
  logic       o_burst_done;
  logic       o_timeout_err;

  i2c_read_burst_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_dev_addr    (i_dev_addr),
    .i_start_addr  (i_start_addr),
    .i_byte_count  (i_byte_count),
    .o_recv_en     (o_recv_en),
    .o_device_addr (o_device_addr),
    .o_data_addr   (o_data_addr),
    .i_read_data   (i_read_data),
    .i_done_flag   (i_done_flag),
    .o_rd_valid    (o_rd_valid),
    .i_rd_ready    (i_rd_ready),
    .o_rd_data     (o_rd_data),
    .o_rd_addr     (o_rd_addr),
    .o_busy        (o_busy),
    .o_burst_done  (o_burst_done),
    .o_timeout_err (o_timeout_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read-master model
  int         model_delay = 10;
  bit         never_done  = 1'b0;
  logic [7:0] data_seed   = 8'h00;
  int         recv_cnt    = 0;
  logic [7:0] addr_log[$];
  logic [6:0] dev_last    = '0;
  int         recv_cyc_last  = 0;
  int         done_cyc_first = -1;
  int         rd_idx      = 0;
  bit         pending     = 1'b0;
  int         wait_ctr    = 0;

  initial begin
    i_done_flag = 1'b0;
    i_read_data = 8'hEE;
    forever begin
      @(negedge clk);
      i_done_flag = 1'b0;
      i_read_data = 8'hEE;
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (wait_ctr == 0) begin
            i_done_flag = 1'b1;
            i_read_data = data_seed + 8'(rd_idx);
            rd_idx++;
            pending = 1'b0;
            if (done_cyc_first < 0) done_cyc_first = cyc;
          end else begin
            wait_ctr--;
          end
        end
        if (o_recv_en) begin
          recv_cnt++;
          addr_log.push_back(o_data_addr);
          dev_last      = o_device_addr;
          recv_cyc_last = cyc;
          if (!never_done) begin
            pending  = 1'b1;
            wait_ctr = model_delay - 1;
          end
        end
      end
    end
  end

  // Consumer monitor
  logic [15:0] got_q[$];
  int          pop_cyc_first = -1;
  int          bursts = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_rd_valid && i_rd_ready) begin
          got_q.push_back({o_rd_data, o_rd_addr});
          if (pop_cyc_first < 0) pop_cyc_first = cyc;
        end
        if (o_burst_done) bursts++;
      end
    end
  end

  // Ready driver: fixed level or one cycle in seven
  bit   throttle  = 1'b0;
  logic ready_req = 1'b1;

  initial begin
    i_rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i_rd_ready = throttle ? ((cyc % 7) == 0) : ready_req;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_logs();
    @(posedge clk);
    #2;
    recv_cnt       = 0;
    addr_log.delete();
    got_q.delete();
    rd_idx         = 0;
    done_cyc_first = -1;
    pop_cyc_first  = -1;
    bursts         = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_req(input logic [6:0] dev, input logic [7:0] start, input logic [7:0] cnt);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #2;
    i_req_valid  = 1'b1;
    i_dev_addr   = dev;
    i_start_addr = start;
    i_byte_count = cnt;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #2;
    i_req_valid = 1'b0;
    check("req_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_burst_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_stream(input string tag, input int n, input logic [7:0] start,
                              input logic [7:0] seed);
    logic [7:0] e_data;
    logic [7:0] e_addr;
    check({tag, "_len"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      e_data = seed + 8'(i);
      e_addr = start + 8'(i);
      check({tag, "_data"}, 32'(got_q[i][15:8]), 32'(e_data));
      check({tag, "_addr"}, 32'(got_q[i][7:0]), 32'(e_addr));
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    i_req_valid  = 1'b0;
    i_dev_addr   = '0;
    i_start_addr = '0;
    i_byte_count = '0;

    // Reset state
    settle(3);
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_recv_en", 32'(o_recv_en), 32'd0);
    check("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    check("rst_burst_done", 32'(o_burst_done), 32'd0);
    check("rst_timeout", 32'(o_timeout_err), 32'd0);
    check("rst_dev_addr", 32'(o_device_addr), 32'd0);
    check("rst_data_addr", 32'(o_data_addr), 32'd0);
    check("rst_rd_data", 32'(o_rd_data), 32'd0);
    check("rst_rd_addr", 32'(o_rd_addr), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // 1: basic three-byte burst, slow read master
    clear_logs();
    model_delay = 100;
    data_seed   = 8'hA1;
    ready_req   = 1'b1;
    send_req(7'h50, 8'h10, 8'd3);
    wait_done("t1_done", 1500);
    check("t1_timeout", 32'(o_timeout_err), 32'd0);
    settle(6);
    check("t1_recv_cnt", recv_cnt, 32'd3);
    check("t1_addr0", 32'(addr_log[0]), 32'h10);
    check("t1_addr1", 32'(addr_log[1]), 32'h11);
    check("t1_addr2", 32'(addr_log[2]), 32'h12);
    check("t1_dev", 32'(dev_last), 32'h50);
    check_stream("t1", 3, 8'h10, 8'hA1);
    check("t1_bursts", bursts, 32'd1);
    check("t1_latency", pop_cyc_first - done_cyc_first, 32'd2);
    check("t1_req_ready", 32'(o_req_ready), 32'd1);
    check("t1_busy", 32'(o_busy), 32'd0);
    check("t1_data_addr_hold", 32'(o_data_addr), 32'h13);

    // 2: register address wraps FF -> 00
    clear_logs();
    model_delay = 5;
    data_seed   = 8'h30;
    send_req(7'h51, 8'hFE, 8'd3);
    wait_done("t2_done", 500);
    settle(6);
    check("t2_addr0", 32'(addr_log[0]), 32'hFE);
    check("t2_addr1", 32'(addr_log[1]), 32'hFF);
    check("t2_addr2", 32'(addr_log[2]), 32'h00);
    check("t2_dev", 32'(dev_last), 32'h51);
    check_stream("t2", 3, 8'hFE, 8'h30);
    check("t2_timeout", 32'(o_timeout_err), 32'd0);
    check("t2_bursts", bursts, 32'd1);

    // 3: consumer stalled, FIFO fills and ISSUE waits
    clear_logs();
    ready_req   = 1'b0;
    model_delay = 5;
    data_seed   = 8'h60;
    send_req(7'h52, 8'h40, 8'd6);
    settle(300);
    check("t3_stalled_reads", recv_cnt, 32'd4);
    check("t3_busy", 32'(o_busy), 32'd1);
    check("t3_rd_valid", 32'(o_rd_valid), 32'd1);
    check("t3_head_data", 32'(o_rd_data), 32'h60);
    check("t3_head_addr", 32'(o_rd_addr), 32'h40);
    settle(3);
    check("t3_head_hold", 32'(o_rd_data), 32'h60);
    check("t3_none_popped", got_q.size(), 32'd0);
    ready_req = 1'b1;
    wait_done("t3_done", 500);
    settle(10);
    check("t3_recv_cnt", recv_cnt, 32'd6);
    check_stream("t3", 6, 8'h40, 8'h60);
    check("t3_bursts", bursts, 32'd1);

    // 4: read master never answers
    clear_logs();
    never_done = 1'b1;
    send_req(7'h53, 8'h20, 8'd2);
    wait_done("t4_done", 400);
    check("t4_timeout_set", 32'(o_timeout_err), 32'd1);
    check("t4_abort_latency", cyc - recv_cyc_last, 32'(TMO) + 32'd1);
    settle(2);
    check("t4_req_ready", 32'(o_req_ready), 32'd1);
    check("t4_timeout_sticky", 32'(o_timeout_err), 32'd1);
    check("t4_recv_cnt", recv_cnt, 32'd1);
    check("t4_no_data", got_q.size(), 32'd0);
    never_done = 1'b0;
    clear_logs();
    data_seed = 8'h99;
    send_req(7'h53, 8'h21, 8'd1);
    check("t4_timeout_cleared", 32'(o_timeout_err), 32'd0);
    wait_done("t4b_done", 300);
    settle(6);
    check_stream("t4b", 1, 8'h21, 8'h99);

    // 5: count 0 = 256 reads with a throttled consumer
    clear_logs();
    model_delay = 2;
    data_seed   = 8'h00;
    throttle    = 1'b1;
    send_req(7'h54, 8'h80, 8'd0);
    wait_done("t5_done", 6000);
    ready_req = 1'b1;
    throttle  = 1'b0;
    settle(20);
    check("t5_recv_cnt", recv_cnt, 32'd256);
    check_stream("t5", 256, 8'h80, 8'h00);
    check("t5_addr_wrapped", 32'(o_data_addr), 32'h80);
    check("t5_timeout", 32'(o_timeout_err), 32'd0);
    check("t5_bursts", bursts, 32'd1);
    check("t5_drained", 32'(o_rd_valid), 32'd0);

    // 6: reset while waiting on the second byte
    clear_logs();
    model_delay = 50;
    data_seed   = 8'hB0;
    send_req(7'h55, 8'h90, 8'd4);
    begin
      bit reached;
      reached = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (recv_cnt == 2) begin
          reached = 1'b1;
          break;
        end
      end
      check("t6_second_issue", 32'(reached), 32'd1);
    end
    settle(10);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req_ready", 32'(o_req_ready), 32'd1);
    check("t6_rst_busy", 32'(o_busy), 32'd0);
    check("t6_rst_rd_valid", 32'(o_rd_valid), 32'd0);
    check("t6_rst_recv_en", 32'(o_recv_en), 32'd0);
    check("t6_rst_data_addr", 32'(o_data_addr), 32'd0);
    check("t6_rst_dev_addr", 32'(o_device_addr), 32'd0);
    check("t6_rst_rd_data", 32'(o_rd_data), 32'd0);
    check("t6_rst_timeout", 32'(o_timeout_err), 32'd0);
    settle(3);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    settle(80);
    check("t6_no_burst_done", bursts, 32'd0);
    check("t6_recv_cnt", recv_cnt, 32'd2);
    check_stream("t6_pre", 1, 8'h90, 8'hB0);
    check("t6_idle", 32'(o_busy), 32'd0);
    clear_logs();
    model_delay = 5;
    data_seed   = 8'h77;
    send_req(7'h56, 8'h05, 8'd2);
    wait_done("t6_done", 300);
    settle(6);
    check_stream("t6_post", 2, 8'h05, 8'h77);
    check("t6_dev", 32'(dev_last), 32'h56);
    check("t6_bursts", bursts, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
